// File: rtl/digit_scroll_scanner.sv
// -----------------------------------------------------------------------------
// digit_scroll_scanner
//   Drives the row scan of an 8x8 LED matrix from a message of up to 8 digits
//   and scrolls that message vertically, one pixel line per scroll step.
//   On each scan tick the glyph ROM address for the current row is registered.
//   On the following edge the combinational ROM data is captured into the
//   column byte, together with the matching one-hot row select.
//
//   The tape is 8 blank lines followed by one 8-line glyph per message digit:
//   T = 8*(len+1) lines. Row cnt of a frame shows tape line (pos+cnt) mod T.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   i_wr_en      write i_wr_data into message slot i_wr_addr
//   i_wr_addr    message slot 0..7 (slot 0 is shown first)
//   i_wr_data    digit code 0..9, 10..15 = blank
//   i_len_we     load message length from i_len_in (clamped to 1..8)
//   i_len_in     message length in digits
//   i_pause      freeze the scroll position; scanning continues
//   o_rom_addr   glyph ROM address (registered)
//   i_rom_data   glyph ROM row pattern, combinational from o_rom_addr
//   o_row        one-hot row select (registered)
//   o_column     column pattern for the active row (registered)
//   o_wrap       one-cycle pulse when the scroll position wraps to 0
// -----------------------------------------------------------------------------
module digit_scroll_scanner #(
    parameter int SCAN_DIV    = 4096,  // clk cycles per row time, >= 2
    parameter int STEP_FRAMES = 128    // frames per scroll step, >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [2:0] i_wr_addr,
    input  logic [3:0] i_wr_data,
    input  logic       i_len_we,
    input  logic [3:0] i_len_in,
    input  logic       i_pause,
    output logic [6:0] o_rom_addr,
    input  logic [7:0] i_rom_data,
    output logic [7:0] o_row,
    output logic [7:0] o_column,
    output logic       o_wrap
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(STEP_FRAMES - 1);

    logic [PW-1:0]   r_pre;
    logic            r_tick_d;
    logic [2:0]      r_cnt;
    logic [FW-1:0]   r_frm;
    logic [6:0]      r_pos;
    logic [3:0]      r_len;
    logic [7:0][3:0] r_buf;
    logic [6:0]      r_rom_addr;
    logic [7:0]      r_row;
    logic [7:0]      r_col;
    logic            r_wrap;

    logic            w_tick;
    logic [6:0]      w_tlen;
    logic [6:0]      w_line_raw;
    logic [6:0]      w_line;
    logic            w_pos_oob;
    logic [3:0]      w_glyph;
    logic [3:0]      w_glyph_m1;
    logic [3:0]      w_code;
    logic [3:0]      w_code_p1;
    logic [6:0]      w_addr_next;
    logic            w_frame_end;
    logic [3:0]      w_len_cl;

    assign w_tick = (r_pre == PRE_LAST);

    // Tape length: 8 blank lines plus 8 per digit (16..72).
    assign w_tlen = {r_len, 3'b000} + 7'd8;

    // pos < T and cnt < 8 <= T, so a single conditional subtract is the modulo.
    assign w_line_raw = r_pos + {4'b0000, r_cnt};
    assign w_line     = (w_line_raw >= w_tlen) ? (w_line_raw - w_tlen) : w_line_raw;

    // After a length shrink pos may sit beyond the new tape until the next
    // step boundary; everything reads blank in that window.
    assign w_pos_oob = (r_pos >= w_tlen);

    assign w_glyph    = w_line[6:3];
    assign w_glyph_m1 = w_glyph - 4'd1;
    assign w_code     = r_buf[w_glyph_m1[2:0]];
    assign w_code_p1  = w_code + 4'd1;

    // Blank glyph lives at ROM 0..7; digit d starts at 8 + 8*d.
    always_comb begin
        w_addr_next = {4'b0000, w_line[2:0]};
        if (!w_pos_oob && (w_glyph != 4'd0) && (w_code <= 4'd9))
            w_addr_next = {w_code_p1, w_line[2:0]};
    end

    // Frame boundary: the row-7 capture edge.
    assign w_frame_end = r_tick_d && (r_cnt == 3'd7);

    always_comb begin
        w_len_cl = i_len_in;
        if (i_len_in == 4'd0)
            w_len_cl = 4'd1;
        else if (i_len_in > 4'd8)
            w_len_cl = 4'd8;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre      <= '0;
            r_tick_d   <= 1'b0;
            r_cnt      <= 3'd0;
            r_frm      <= '0;
            r_pos      <= 7'd0;
            r_len      <= 4'd1;
            r_buf      <= '1;
            r_rom_addr <= 7'd0;
            r_row      <= 8'h00;
            r_col      <= 8'h00;
            r_wrap     <= 1'b0;
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_tick_d <= w_tick;
            r_wrap   <= 1'b0;

            // Buffer reads happen on this edge too, so a same-cycle write to
            // the addressed slot still yields the old code for this row.
            if (w_tick)
                r_rom_addr <= w_addr_next;

            // Row and column updated together so they can never disagree.
            if (r_tick_d) begin
                r_row <= 8'h01 << r_cnt;
                r_col <= i_rom_data;
                r_cnt <= r_cnt + 3'd1;
            end

            // While paused the frame count sits at its last value, so the
            // step fires at the first frame end after release.
            if (w_frame_end) begin
                if (r_frm != FRM_LAST) begin
                    r_frm <= r_frm + 1'b1;
                end else if (!i_pause) begin
                    r_frm <= '0;
                    if (w_pos_oob) begin
                        r_pos <= 7'd0;
                    end else if (r_pos == w_tlen - 7'd1) begin
                        r_pos  <= 7'd0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_pos <= r_pos + 7'd1;
                    end
                end
            end

            if (i_wr_en)
                r_buf[i_wr_addr] <= i_wr_data;

            if (i_len_we)
                r_len <= w_len_cl;
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_row      = r_row;
    assign o_column   = r_col;
    assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_digit_scroll_scanner.sv
// -----------------------------------------------------------------------------
// tb_digit_scroll_scanner
//   Directed bench for digit_scroll_scanner with SCAN_DIV=4, STEP_FRAMES=1,
//   so one frame is 32 cycles and the scroll position advances every frame.
//   A small glyph ROM model answers rom_addr: 0..7 blank, digit '1' uses the
//   reference pattern, every other address returns {1'b1, addr}.
// -----------------------------------------------------------------------------
module tb_digit_scroll_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       len_we;
    logic [3:0] len_in;
    logic       pause;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] row;
    logic [7:0] column;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_scroll_scanner #(.SCAN_DIV(4), .STEP_FRAMES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_len_we   (len_we),
        .i_len_in   (len_in),
        .i_pause    (pause),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_row      (row),
        .o_column   (column),
        .o_wrap     (wrap)
    );

    function automatic logic [7:0] rom_model(input logic [6:0] a);
        logic [7:0] one [8];
        one = '{8'h08, 8'h18, 8'h08, 8'h08, 8'h08, 8'h08, 8'h1C, 8'h00};
        if (a < 7'd8)
            return 8'h00;
        if (a >= 7'd16 && a < 7'd24)
            return one[a[2:0]];
        return {1'b1, a};
    endfunction

    assign rom_data = rom_model(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_row(input logic [7:0] r);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row == r) break;
        end
    endtask

    task automatic wait_pos(input int p, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (int'(dut.r_pos) == p) break;
        end
    endtask

    // Cycles from one wrap pulse to the next (0 if none within lim).
    task automatic wrap_period(input int lim, output int per);
        per = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (wrap) break;
        end
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (wrap) begin
                per = i;
                break;
            end
        end
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_len(input logic [3:0] l);
        len_we = 1'b1; len_in = l;
        @(negedge clk);
        len_we = 1'b0;
    endtask

    initial begin
        logic [7:0] exp1 [8];
        int         p, prev, per, changes, waited;
        logic [7:0] last_row;
        logic       seen_wrap;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        len_we = 1'b0; len_in = 4'd0; pause = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_row",      32'(row),      32'h00);
        chk("rst_column",   32'(column),   32'h00);
        chk("rst_rom_addr", 32'(rom_addr), 32'h00);
        chk("rst_wrap",     32'(wrap),     32'h0);
        rst = 1'b0;

        // 1: all-blank tape, row walks 01..80
        for (int k = 0; k < 8; k++) begin
            wait_row(8'h01 << k);
            chk("t1_row",    32'(row),    32'(8'h01 << k));
            chk("t1_column", 32'(column), 32'h00);
        end

        // 2: slot0='1', len=1 (write and length load in the same cycle)
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd1;
        len_we = 1'b1; len_in = 4'd1;
        @(negedge clk);
        wr_en = 1'b0; len_we = 1'b0;
        exp1 = '{8'h08, 8'h18, 8'h08, 8'h08, 8'h08, 8'h08, 8'h1C, 8'h00};
        wait_pos(8, 1200);
        chk("t2_pos", dut.r_pos, 32'd8);
        for (int k = 0; k < 8; k++) begin
            wait_row(8'h01 << k);
            chk("t2_row",    32'(row),    32'(8'h01 << k));
            chk("t2_column", 32'(column), 32'(exp1[k]));
        end

        // 3: "2","3", T=24
        write_slot(3'd0, 4'd2);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd3;
        len_we = 1'b1; len_in = 4'd2;
        @(negedge clk);
        wr_en = 1'b0; len_we = 1'b0;
        wait_pos(16, 1200);
        wait_row(8'h01);
        chk("t3_pos16_row0", 32'(column), 32'hA0);      // line 16: digit 3 line 0
        wait_pos(20, 400);
        wait_row(8'h08);
        chk("t3_pos20_row3", 32'(column), 32'hA7);      // line 23: digit 3 line 7
        wait_row(8'h10);
        chk("t3_pos20_row4", 32'(column), 32'h00);      // line 24 -> 0: blank
        prev = int'(dut.r_pos);
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (wrap) break;
            prev = int'(dut.r_pos);
        end
        chk("t3_wrap_seen",  32'(wrap),     32'h1);
        chk("t3_pos_before", 32'(prev),     32'd23);
        chk("t3_pos_after",  dut.r_pos,     32'd0);
        @(negedge clk);
        chk("t3_wrap_width", 32'(wrap),     32'h0);
        per = 0;
        for (int i = 2; i <= 900; i++) begin
            @(negedge clk);
            if (wrap) begin
                per = i;
                break;
            end
        end
        chk("t3_wrap_period", 32'(per), 32'd768);       // 24 frames * 32 cycles

        // 4: pause over 5 frames
        pause = 1'b1;
        p = int'(dut.r_pos);
        changes = 0;
        last_row = row;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (row != last_row) changes++;
            last_row = row;
        end
        chk("t4_pos_held",   dut.r_pos,     32'(p));
        chk("t4_row_scans",  32'(changes),  32'd40);
        pause = 1'b0;
        waited = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (int'(dut.r_pos) != p) begin
                waited = i;
                break;
            end
        end
        chk("t4_resume_pos", dut.r_pos, 32'((p == 23) ? 0 : p + 1));
        chk("t4_resume_in_frame", 32'(waited != 0 && waited <= 32), 32'h1);

        // 5: shrink at pos=20 -> forced reset without wrap
        wait_pos(20, 900);
        load_len(4'd1);
        wait_row(8'h01);
        chk("t5_oob_blank", 32'(column), 32'h00);
        seen_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wrap) seen_wrap = 1'b1;
            if (dut.r_pos != 7'd20) break;
        end
        chk("t5_pos_reset", dut.r_pos,      32'd0);
        chk("t5_no_wrap",   32'(seen_wrap), 32'h0);
        load_len(4'd12);
        wrap_period(2500, per);
        chk("t5_len12_period", 32'(per), 32'd2304);     // 72 frames
        load_len(4'd0);
        wrap_period(2500, per);
        chk("t5_len0_period",  32'(per), 32'd512);      // 16 frames

        // 6: reset mid-frame
        write_slot(3'd0, 4'd2);
        wait_row(8'h10);
        chk("t6_pre_row", 32'(row), 32'h10);
        rst = 1'b1;
        #1;
        chk("t6_row",      32'(row),      32'h00);
        chk("t6_column",   32'(column),   32'h00);
        chk("t6_rom_addr", 32'(rom_addr), 32'h00);
        chk("t6_wrap",     32'(wrap),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row != 8'h00) break;
        end
        chk("t6_first_row", 32'(row), 32'h01);
        wait_pos(8, 400);
        for (int k = 0; k < 8; k++) begin
            wait_row(8'h01 << k);
            chk("t6_buf_blank", 32'(column), 32'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
